// File: rtl/param_bus_sequencer.sv
// param_bus_sequencer: turns a command stream into single-cycle peripheral bus accesses.
// Optional write readback check: define PARAM_SEQ_WRITE_VERIFY_EN.
module param_bus_sequencer #(
   parameter int AddrWidth = 14,
   parameter int DataWidth = 16,
   parameter int LenWidth  = 8
) (
   input  logic                 Clk_i,
   input  logic                 Reset_i,
   input  logic                 Cmd_Valid_i,
   output logic                 Cmd_Ready_o,
   input  logic                 Cmd_Write_i,
   input  logic [AddrWidth-1:0] Cmd_Addr_i,
   input  logic [DataWidth-1:0] Cmd_Data_i,
   input  logic [LenWidth-1:0]  Cmd_Len_i,
   output logic                 Rsp_Valid_o,
   input  logic                 Rsp_Ready_i,
   output logic [DataWidth-1:0] Rsp_Data_o,
   output logic                 Rsp_Last_o,
   output logic [AddrWidth-1:0] PerAddr_o,
   output logic [DataWidth-1:0] PerDIn_o,
   output logic [1:0]           PerWr_o,
   output logic                 PerEn_o,
   input  logic [DataWidth-1:0] PerDOut_i,
`ifdef PARAM_SEQ_WRITE_VERIFY_EN
   output logic                 Verify_Err_o,
`endif
   output logic                 Busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_CAP,
      S_RSP
`ifdef PARAM_SEQ_WRITE_VERIFY_EN
      ,
      S_VFY_RD,
      S_VFY_CAP
`endif
   } state_t;

   state_t state_q, state_d;

   logic [AddrWidth-1:0] addr_q;
   logic [DataWidth-1:0] data_q;
   logic [LenWidth-1:0]  len_q;
   logic [DataWidth-1:0] rsp_data_q;
   logic                 cmd_hs;
   logic                 rsp_hs;
   logic                 last;

   assign cmd_hs = (state_q == S_IDLE) && Cmd_Valid_i;
   assign rsp_hs = (state_q == S_RSP) && Rsp_Ready_i;
   assign last   = (len_q == '0);

   always_ff @(posedge Clk_i) begin
      if (Reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (Cmd_Valid_i) state_d = Cmd_Write_i ? S_WR : S_RD;
`ifdef PARAM_SEQ_WRITE_VERIFY_EN
         S_WR:      state_d = S_VFY_RD;
         S_VFY_RD:  state_d = S_VFY_CAP;
         S_VFY_CAP: state_d = S_IDLE;
`else
         S_WR:      state_d = S_IDLE;
`endif
         S_RD:      state_d = S_CAP;
         S_CAP:     state_d = S_RSP;
         S_RSP:     if (Rsp_Ready_i) state_d = last ? S_IDLE : S_RD;
         default:   state_d = S_IDLE;
      endcase
   end

   // Bus outputs are forced to zero outside strobe states: the bus is OR-combined.
   always_comb begin
      Cmd_Ready_o = 1'b0;
      Busy_o      = 1'b1;
      Rsp_Valid_o = 1'b0;
      PerEn_o     = 1'b0;
      PerWr_o     = 2'b00;
      PerAddr_o   = '0;
      PerDIn_o    = '0;
      unique case (state_q)
         S_IDLE: begin
            Cmd_Ready_o = 1'b1;
            Busy_o      = 1'b0;
         end
         S_WR: begin
            PerEn_o   = 1'b1;
            PerWr_o   = 2'b11;
            PerAddr_o = addr_q;
            PerDIn_o  = data_q;
         end
`ifdef PARAM_SEQ_WRITE_VERIFY_EN
         S_RD, S_VFY_RD: begin
`else
         S_RD: begin
`endif
            PerEn_o   = 1'b1;
            PerAddr_o = addr_q;
         end
         S_RSP:   Rsp_Valid_o = 1'b1;
         default: ;
      endcase
   end

   assign Rsp_Last_o = (state_q == S_RSP) && last;
   assign Rsp_Data_o = rsp_data_q;

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         addr_q     <= '0;
         data_q     <= '0;
         len_q      <= '0;
         rsp_data_q <= '0;
      end else begin
         if (cmd_hs) begin
            addr_q <= Cmd_Addr_i;
            data_q <= Cmd_Data_i;
            len_q  <= Cmd_Len_i;
         end
         if (state_q == S_CAP) rsp_data_q <= PerDOut_i;
         // Burst step; the address wraps silently at the top of the space.
         if (rsp_hs && !last) begin
            addr_q <= addr_q + AddrWidth'(1);
            len_q  <= len_q - LenWidth'(1);
         end
      end
   end

`ifdef PARAM_SEQ_WRITE_VERIFY_EN
   logic err_q;

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         err_q <= 1'b0;
      end else if (state_q == S_VFY_CAP && PerDOut_i != data_q) begin
         err_q <= 1'b1;
      end
   end

   assign Verify_Err_o = err_q;
`endif

endmodule
